tex_scan_loader: RTL

Serial texture-load front end of the tiniest GPU. It deserialises the two-phase texture scan chain (phi1/phi2 strobes, serial data, latch strobe) into 11-bit address / 8-bit data write requests for the 2048 x 8 texture RAM. It counts completed writes and flags malformed frames. It sits between the uio_in scan pins and the texture memory write port.

---
 rtl/tex_scan_loader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/tex_scan_loader.sv
// ---------------------------------------------------------------------------
// tex_scan_loader: two-phase texture scan chain to texture-RAM write requests.
// Optional: TEX_SCAN_SDO_EN adds registered sdo (chain[18]) for loopback.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tex_scan_loader #(
  parameter int SYNC_STAGES = 2,
  parameter int TEX_WORDS   = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phi1,
  input  logic        phi2,
  input  logic        sdi,
  input  logic        latch,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        load_done,
  output logic        frame_err,
  output logic        ovf_err
`ifdef TEX_SCAN_SDO_EN
  ,
  output logic        sdo
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [4:0]  FRAME_BITS = 5'd20;
  localparam logic [11:0] WORDS_LIM  = 12'(TEX_WORDS);

  // Each sync stage carries {latch, sdi, phi2, phi1} side by side.
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [2:0]  edge_q, edge_d;
  logic        master_q, master_d;
  logic [18:0] chain_q, chain_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  state_t      state_q, state_d;
  logic        wr_valid_q, wr_valid_d;
  logic [10:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [11:0] wr_count_q, wr_count_d;
  logic        load_done_q, load_done_d;
  logic        frame_err_q, frame_err_d;
  logic        ovf_err_q, ovf_err_d;
`ifdef TEX_SCAN_SDO_EN
  logic        sdo_q, sdo_d;
`endif

  logic [3:0] s;
  logic       phi1_rise, phi2_rise, latch_rise;

  assign s          = sync_q[SYNC_STAGES-1];
  assign phi1_rise  = s[0] & ~edge_q[0];
  assign phi2_rise  = s[1] & ~edge_q[1];
  assign latch_rise = s[3] & ~edge_q[2];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], latch, sdi, phi2, phi1};
    edge_d      = {s[3], s[1], s[0]};
    master_d    = master_q;
    chain_d     = chain_q;
    bit_cnt_d   = bit_cnt_q;
    state_d     = state_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_count_d  = wr_count_q;
    load_done_d = load_done_q;
    frame_err_d = frame_err_q;
    ovf_err_d   = ovf_err_q;
`ifdef TEX_SCAN_SDO_EN
    sdo_d       = sdo_q;
`endif

    if (phi1_rise) begin
      master_d = s[2];
    end

    if (phi2_rise) begin
      unique case (state_q)
        IDLE: begin
          // Ones on an idle line are discarded; a zero is the start bit.
          if (!master_q) begin
            state_d   = SHIFT;
            bit_cnt_d = 5'd1;
            chain_d   = '0;
          end
        end
        SHIFT: begin
          chain_d   = {chain_q[17:0], master_q};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_d == FRAME_BITS) begin
            state_d = FULL;
          end
        end
        FULL: begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
          bit_cnt_d   = 5'd0;
          chain_d     = '0;
        end
        default: state_d = IDLE;
      endcase
`ifdef TEX_SCAN_SDO_EN
      sdo_d = chain_d[18];
`endif
    end

    // The latch sees the post-shift state when both strobes land together.
    if (latch_rise) begin
      unique case (state_d)
        SHIFT: begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
          bit_cnt_d   = 5'd0;
          chain_d     = '0;
        end
        FULL: begin
          if (wr_valid_q) begin
            ovf_err_d = 1'b1;
          end else begin
            wr_valid_d = 1'b1;
            wr_addr_d  = chain_d[18:8];
            wr_data_d  = chain_d[7:0];
          end
          state_d   = IDLE;
          bit_cnt_d = 5'd0;
          chain_d   = '0;
        end
        default: ;
      endcase
    end

    if (wr_valid_q && wr_ready) begin
      wr_valid_d = 1'b0;
      if (wr_count_q != WORDS_LIM) begin
        wr_count_d = wr_count_q + 12'd1;
      end
    end
    if (wr_count_d == WORDS_LIM) begin
      load_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      edge_q      <= '0;
      master_q    <= 1'b0;
      chain_q     <= '0;
      bit_cnt_q   <= '0;
      state_q     <= IDLE;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_count_q  <= '0;
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
`ifdef TEX_SCAN_SDO_EN
      sdo_q       <= 1'b0;
`endif
    end else begin
      sync_q      <= sync_d;
      edge_q      <= edge_d;
      master_q    <= master_d;
      chain_q     <= chain_d;
      bit_cnt_q   <= bit_cnt_d;
      state_q     <= state_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_count_q  <= wr_count_d;
      load_done_q <= load_done_d;
      frame_err_q <= frame_err_d;
      ovf_err_q   <= ovf_err_d;
`ifdef TEX_SCAN_SDO_EN
      sdo_q       <= sdo_d;
`endif
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign load_done = load_done_q;
  assign frame_err = frame_err_q;
  assign ovf_err   = ovf_err_q;
`ifdef TEX_SCAN_SDO_EN
  assign sdo       = sdo_q;
`endif

endmodule

`default_nettype wire
